// File: rtl/count_run_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | count_run_controller                                                      |
// | Button debounce, paced count-enable tick, direction and IDLE/RUN/PAUSE/  |
// | DONE sequencing for the 4-digit up/down 7-segment counter.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module count_run_controller #(
   parameter int CLK_HZ          = 100_000_000,
   parameter int TICK_HZ         = 1,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       progressive,
   input  logic       regressive,
   input  logic       finish,
   output logic       enable,
   output logic       forward,
   output logic       clear,
   output logic [1:0] state,
   output logic       running
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

   localparam logic [PW-1:0]  c_PRESC_MAX = PW'(DIV - 1);
   localparam logic [DBW-1:0] c_DB_MAX    = DBW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_DONE  = 2'b11;

   logic [3:0]    w_raw;
   logic [3:0]    w_press;
   logic          w_start_p;
   logic          w_pause_p;
   logic          w_prog_p;
   logic          w_regr_p;

   logic [1:0]    r_state;
   logic [1:0]    w_next;
   logic          w_clear_nxt;
   logic          r_enable;
   logic          r_clear;
   logic          r_forward;
   logic [PW-1:0] r_presc;

   assign w_raw = {regressive, progressive, pause, start};

   // Each button: 2-FF sync, level accepted after c_DB_MAX+1 stable cycles, rising-edge pulse.
   for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic           r_s1;
      logic           r_s2;
      logic           r_lvl;
      logic           r_lvl_d;
      logic [DBW-1:0] r_cnt;

      always_ff @(posedge clk_100MHz) begin
         if (reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
            r_cnt   <= '0;
         end else begin
            r_s1    <= w_raw[gi];
            r_s2    <= r_s1;
            r_lvl_d <= r_lvl;
            if (r_s2 == r_lvl) begin
               r_cnt <= '0;
            end else if (r_cnt == c_DB_MAX) begin
               r_cnt <= '0;
               r_lvl <= r_s2;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end

      assign w_press[gi] = r_lvl & ~r_lvl_d;
   end

   assign w_start_p = w_press[0];
   assign w_pause_p = w_press[1];
   assign w_prog_p  = w_press[2];
   assign w_regr_p  = w_press[3];

   always_comb begin
      w_next      = r_state;
      w_clear_nxt = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_start_p) begin
               w_next      = S_RUN;
               w_clear_nxt = 1'b1;
            end
         end
         S_RUN: begin
            // A finish still high from before the reload is stale while clear is out.
            if (finish && !r_clear) begin
               w_next = S_DONE;
            end else if (w_pause_p) begin
               w_next = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (w_start_p || w_pause_p) begin
               w_next = S_RUN;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_enable  <= 1'b0;
         r_clear   <= 1'b0;
         r_forward <= 1'b1;
         r_presc   <= '0;
      end else begin
         r_state  <= w_next;
         r_clear  <= w_clear_nxt;
         r_enable <= (r_state == S_RUN) && (r_presc == c_PRESC_MAX) && !finish && !r_clear;

         if (w_clear_nxt) begin
            r_presc <= '0;
         end else if (r_state == S_RUN) begin
            r_presc <= (r_presc == c_PRESC_MAX) ? '0 : r_presc + 1'b1;
         end

         if (r_state != S_RUN) begin
            if (w_prog_p && !w_regr_p) begin
               r_forward <= 1'b1;
            end else if (w_regr_p && !w_prog_p) begin
               r_forward <= 1'b0;
            end
         end
      end
   end

   assign enable  = r_enable;
   assign clear   = r_clear;
   assign forward = r_forward;
   assign state   = r_state;
   assign running = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_count_run_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_count_run_controller                                                   |
// | Directed self-checking bench, DIV=10, DEBOUNCE_CYCLES=4.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_count_run_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       pause;
   logic       progressive;
   logic       regressive;
   logic       finish;
   logic       enable;
   logic       forward;
   logic       clear;
   logic [1:0] state;
   logic       running;

   int checks = 0;
   int errors = 0;

   count_run_controller #(
      .CLK_HZ          (100),
      .TICK_HZ         (10),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk_100MHz  (clk),
      .reset       (reset),
      .start       (start),
      .pause       (pause),
      .progressive (progressive),
      .regressive  (regressive),
      .finish      (finish),
      .enable      (enable),
      .forward     (forward),
      .clear       (clear),
      .state       (state),
      .running     (running)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_enable;
      int n;
      n = 0;
      while (enable !== 1'b1 && n < 25) begin
         tick();
         n++;
      end
      checks++;
      if (enable !== 1'b1) begin
         errors++;
         $display("FAIL wait_enable: enable=%b after %0d cycles, required 1", enable, n);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b required 00", state); end
      checks++;
      if (forward !== 1'b1) begin errors++; $display("FAIL reset_forward: got %b required 1", forward); end
      checks++;
      if ({enable, clear, running} !== 3'b000) begin
         errors++;
         $display("FAIL reset_outs: enable/clear/running got %b required 000", {enable, clear, running});
      end
      reset = 1'b0;
   endtask

   task automatic test_bounce;
      for (int i = 0; i < 20; i++) begin
         start = ((i / 2) % 2 == 0);
         tick();
         checks++;
         if (state !== 2'b00 || clear !== 1'b0) begin
            errors++;
            $display("FAIL bounce_c%0d: state=%b clear=%b required 00/0", i, state, clear);
         end
      end
      start = 1'b0;
      repeat (6) tick();
      checks++;
      if (state !== 2'b00) begin errors++; $display("FAIL bounce_end: state=%b required 00", state); end
   endtask

   task automatic test_start;
      logic [1:0] exp_st;
      start = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (k == 10) start = 1'b0;
         exp_st = (k >= 7) ? 2'b01 : 2'b00;
         checks++;
         if (state !== exp_st || running !== (k >= 7)) begin
            errors++;
            $display("FAIL start_state_c%0d: state=%b running=%b required %b", k, state, running, exp_st);
         end
         checks++;
         if (clear !== (k == 7)) begin
            errors++;
            $display("FAIL start_clear_c%0d: clear=%b required %b", k, clear, (k == 7));
         end
         checks++;
         if (enable !== (k == 17 || k == 27)) begin
            errors++;
            $display("FAIL start_enable_c%0d: enable=%b required %b", k, enable, (k == 17 || k == 27));
         end
      end
   endtask

   task automatic test_pause_resume;
      int n;
      wait_enable();
      pause = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         checks++;
         if (state !== ((k == 7) ? 2'b10 : 2'b01) || enable !== 1'b0) begin
            errors++;
            $display("FAIL pause_enter_c%0d: state=%b enable=%b", k, state, enable);
         end
      end
      repeat (3) tick();
      pause = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         checks++;
         if (state !== 2'b10 || enable !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold_c%0d: state=%b enable=%b required 10/0", k, state, enable);
         end
      end
      pause = 1'b1;
      n = 0;
      while (state !== 2'b01 && n < 12) begin
         tick();
         n++;
      end
      checks++;
      if (state !== 2'b01) begin errors++; $display("FAIL resume_state: state=%b required 01", state); end
      pause = 1'b0;
      for (int k = 0; k <= 3; k++) begin
         if (k > 0) tick();
         checks++;
         if (enable !== (k == 3)) begin
            errors++;
            $display("FAIL resume_enable_r%0d: enable=%b required %b", k, enable, (k == 3));
         end
      end
   endtask

   task automatic test_finish_restart;
      int n;
      wait_enable();
      repeat (9) tick();
      checks++;
      if (enable !== 1'b0 || state !== 2'b01) begin
         errors++;
         $display("FAIL finish_pre: enable=%b state=%b required 0/01", enable, state);
      end
      finish = 1'b1;
      tick();
      checks++;
      if (enable !== 1'b0) begin errors++; $display("FAIL finish_mask: enable=%b required 0", enable); end
      checks++;
      if (state !== 2'b11 || running !== 1'b0) begin
         errors++;
         $display("FAIL finish_done: state=%b running=%b required 11/0", state, running);
      end
      regressive = 1'b1;
      repeat (8) tick();
      regressive = 1'b0;
      repeat (6) tick();
      checks++;
      if (forward !== 1'b0 || state !== 2'b11) begin
         errors++;
         $display("FAIL done_dir: forward=%b state=%b required 0/11", forward, state);
      end
      start = 1'b1;
      n = 0;
      while (clear !== 1'b1 && n < 12) begin
         tick();
         n++;
      end
      checks++;
      if (clear !== 1'b1 || state !== 2'b01) begin
         errors++;
         $display("FAIL restart_clear: clear=%b state=%b required 1/01", clear, state);
      end
      tick();
      checks++;
      if (state !== 2'b01 || clear !== 1'b0) begin
         errors++;
         $display("FAIL restart_stale_finish: state=%b clear=%b required 01/0", state, clear);
      end
      finish = 1'b0;
      start  = 1'b0;
      tick();
      checks++;
      if (state !== 2'b01) begin errors++; $display("FAIL restart_run: state=%b required 01", state); end
   endtask

   task automatic test_dir_and_reset;
      test_reset();
      start = 1'b1;
      repeat (10) tick();
      start = 1'b0;
      checks++;
      if (state !== 2'b01) begin errors++; $display("FAIL t6_run: state=%b required 01", state); end
      regressive = 1'b1;
      repeat (8) tick();
      regressive = 1'b0;
      repeat (4) tick();
      checks++;
      if (forward !== 1'b1) begin errors++; $display("FAIL t6_dir_in_run: forward=%b required 1", forward); end
      pause = 1'b1;
      repeat (8) tick();
      pause = 1'b0;
      repeat (4) tick();
      checks++;
      if (state !== 2'b10) begin errors++; $display("FAIL t6_pause: state=%b required 10", state); end
      progressive = 1'b1;
      regressive  = 1'b1;
      repeat (8) tick();
      progressive = 1'b0;
      regressive  = 1'b0;
      repeat (4) tick();
      checks++;
      if (forward !== 1'b1) begin errors++; $display("FAIL t6_both: forward=%b required 1", forward); end
      regressive = 1'b1;
      repeat (8) tick();
      regressive = 1'b0;
      repeat (4) tick();
      checks++;
      if (forward !== 1'b0) begin errors++; $display("FAIL t6_regr_pause: forward=%b required 0", forward); end
      start = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (clear !== 1'b0) begin errors++; $display("FAIL t6_resume_clear_c%0d: clear=%b required 0", k, clear); end
      end
      start = 1'b0;
      checks++;
      if (state !== 2'b01) begin errors++; $display("FAIL t6_resume: state=%b required 01", state); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (state !== 2'b00 || forward !== 1'b1 || {enable, clear, running} !== 3'b000) begin
         errors++;
         $display("FAIL t6_midrun_reset: state=%b forward=%b en/clr/run=%b required 00/1/000",
                  state, forward, {enable, clear, running});
      end
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      pause       = 1'b0;
      progressive = 1'b0;
      regressive  = 1'b0;
      finish      = 1'b0;
      @(negedge clk);
      test_reset();
      test_bounce();
      test_start();
      test_pause_resume();
      test_finish_restart();
      test_dir_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
